// File: rtl/wf_fetch_scheduler_pkg.sv
// wf_fetch_scheduler_pkg: shared slot-state encodings and sizing constants
package wf_fetch_scheduler_pkg;
  localparam int NUM_WF = 40;
  localparam int WFID_W = 6;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;
  typedef enum logic [1:0] {
    WF_IDLE    = 2'd0,
    WF_READY   = 2'd1,
    WF_PENDING = 2'd2
  } wf_state_e;
endpackage

// File: rtl/wf_fetch_scheduler_arb.sv
// rr_arbiter_40: combinational round-robin pick of the first eligible slot after rr_ptr
// ports: eligible/rr_ptr/en in; grant_valid/grant_id out
module rr_arbiter_40
  import wf_fetch_scheduler_pkg::*;
(
  input  logic [NUM_WF-1:0] eligible,
  input  logic [WFID_W-1:0] rr_ptr,
  input  logic              en,
  output logic              grant_valid,
  output logic [WFID_W-1:0] grant_id
);
  logic [WFID_W-1:0] idx;
  // scanning from the farthest offset down leaves the nearest eligible slot as the last writer
  always_comb begin
    grant_valid = 1'b0;
    grant_id = '0;
    idx = '0;
    for (int k = NUM_WF; k >= 1; k--) begin
      idx = WFID_W'((32'(rr_ptr) + 32'(k)) % NUM_WF);
      if (en && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_id = idx;
      end
    end
  end
endmodule

// File: rtl/wf_fetch_scheduler.sv
// wf_fetch_scheduler: per-wavefront PC/fetch tracking with round-robin fetch issue
// ports: dispatch_* launch a slot; fetch_stop_fetch blocks slots; buff_ready/buff2fetchwave_ack
// talk to the instruction buffer; salu_branch_* redirect; issue_wf_done_* retire;
// fetch_buff_*/fetch_reserve_* are the registered requests; buff_squash drops stale acks;
// active_count counts busy slots; sched_err is a sticky protocol-error flag
module wf_fetch_scheduler
  import wf_fetch_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              dispatch_valid,
  input  logic [WFID_W-1:0] dispatch_wfid,
  input  logic [PC_W-1:0]   dispatch_pc,
  input  logic [NUM_WF-1:0] fetch_stop_fetch,
  input  logic              buff_ready,
  input  logic              buff2fetchwave_ack,
  input  logic [WFID_W-1:0] buff_ack_wfid,
  input  logic              salu_branch_en,
  input  logic [WFID_W-1:0] salu_branch_wfid,
  input  logic              salu_branch_taken,
  input  logic [PC_W-1:0]   salu_branch_target,
  input  logic              issue_wf_done_en,
  input  logic [WFID_W-1:0] issue_wf_done_wf_id,
  output logic              fetch_reserve_valid,
  output logic [WFID_W-1:0] fetch_reserve_slotid,
  output logic              fetch_buff_valid,
  output logic [WFID_W-1:0] fetch_buff_wfid,
  output logic [PC_W-1:0]   fetch_buff_addr,
  output logic              buff_squash,
  output logic [WFID_W-1:0] active_count,
  output logic              sched_err
);
  wf_state_e state_q [NUM_WF];
  wf_state_e state_d [NUM_WF];
  logic [PC_W-1:0] pc_q [NUM_WF];
  logic [PC_W-1:0] pc_d [NUM_WF];
  logic [NUM_WF-1:0] squash_q, squash_d, drain_q, drain_d;
  logic [NUM_WF-1:0] eligible, pend, done_hit, br_hit, ack_hit, disp_hit;
  logic [WFID_W-1:0] rr_ptr_q, grant_id, active_d, active_q, wfid_q;
  logic [PC_W-1:0] addr_q;
  logic grant_valid, valid_q, err_q, err_d, ack_ok;
  // a slot being retired or redirected this cycle must not also be granted
  always_comb begin
    pend = '0;
    done_hit = '0;
    br_hit = '0;
    ack_hit = '0;
    disp_hit = '0;
    eligible = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      pend[i] = state_q[i] == WF_PENDING;
      done_hit[i] = issue_wf_done_en && issue_wf_done_wf_id == WFID_W'(i);
      br_hit[i] = salu_branch_en && salu_branch_taken && salu_branch_wfid == WFID_W'(i) && state_q[i] != WF_IDLE;
      ack_hit[i] = buff2fetchwave_ack && buff_ack_wfid == WFID_W'(i);
      disp_hit[i] = dispatch_valid && dispatch_wfid == WFID_W'(i);
      eligible[i] = state_q[i] == WF_READY && !fetch_stop_fetch[i] && !done_hit[i] && !br_hit[i];
    end
  end
  rr_arbiter_40 u_arb (
    .eligible    (eligible),
    .rr_ptr      (rr_ptr_q),
    .en          (buff_ready),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );
  // per slot: done > branch > ack > grant, then dispatch onto whatever done left behind
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    squash_d = squash_q;
    drain_d = drain_q;
    buff_squash = 1'b0;
    ack_ok = 1'b0;
    err_d = err_q;
    active_d = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      if (ack_hit[i]) begin
        ack_ok = pend[i] || drain_q[i];
        buff_squash = squash_q[i] || (drain_q[i] && !pend[i]) || (pend[i] && (done_hit[i] || br_hit[i]));
        drain_d[i] = 1'b0;
      end
      if (done_hit[i]) begin
        state_d[i] = WF_IDLE;
        squash_d[i] = 1'b0;
        if (pend[i] && !ack_hit[i]) drain_d[i] = 1'b1;
      end else if (br_hit[i]) begin
        pc_d[i] = salu_branch_target;
        if (pend[i]) begin
          state_d[i] = ack_hit[i] ? WF_READY : WF_PENDING;
          squash_d[i] = !ack_hit[i];
        end
      end else if (ack_hit[i] && pend[i]) begin
        state_d[i] = WF_READY;
        squash_d[i] = 1'b0;
      end else if (grant_valid && grant_id == WFID_W'(i)) begin
        state_d[i] = WF_PENDING;
        pc_d[i] = pc_q[i] + PC_INC;
      end
      if (disp_hit[i]) begin
        if (state_d[i] == WF_IDLE) begin
          state_d[i] = WF_READY;
          pc_d[i] = dispatch_pc;
          squash_d[i] = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
      active_d = active_d + WFID_W'(state_d[i] != WF_IDLE);
    end
    err_d = err_d || (buff2fetchwave_ack && !ack_ok);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '{default: WF_IDLE};
      pc_q <= '{default: '0};
      squash_q <= '0;
      drain_q <= '0;
      rr_ptr_q <= WFID_W'(NUM_WF - 1);
      valid_q <= 1'b0;
      wfid_q <= '0;
      addr_q <= '0;
      active_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      squash_q <= squash_d;
      drain_q <= drain_d;
      rr_ptr_q <= grant_valid ? grant_id : rr_ptr_q;
      valid_q <= grant_valid;
      wfid_q <= grant_valid ? grant_id : '0;
      addr_q <= grant_valid ? pc_q[grant_id] : '0;
      active_q <= active_d;
      err_q <= err_d;
    end
  end
  assign fetch_buff_valid = valid_q;
  assign fetch_reserve_valid = valid_q;
  assign fetch_buff_wfid = wfid_q;
  assign fetch_reserve_slotid = wfid_q;
  assign fetch_buff_addr = addr_q;
  assign active_count = active_q;
  assign sched_err = err_q;
endmodule

// File: tb/tb_wf_fetch_scheduler.sv
// tb_wf_fetch_scheduler: directed scenarios plus random traffic against an event-level slot model
module tb_wf_fetch_scheduler;
  logic clk = 1'b0, rst = 1'b1;
  logic dispatch_valid = 1'b0, buff_ready = 1'b0, buff2fetchwave_ack = 1'b0;
  logic salu_branch_en = 1'b0, salu_branch_taken = 1'b0, issue_wf_done_en = 1'b0;
  logic [5:0] dispatch_wfid = '0, buff_ack_wfid = '0, salu_branch_wfid = '0, issue_wf_done_wf_id = '0;
  logic [31:0] dispatch_pc = '0, salu_branch_target = '0;
  logic [39:0] fetch_stop_fetch = '0;
  logic fetch_reserve_valid, fetch_buff_valid, buff_squash, sched_err;
  logic [5:0] fetch_reserve_slotid, fetch_buff_wfid, active_count;
  logic [31:0] fetch_buff_addr;
  always #5 clk = ~clk;
  wf_fetch_scheduler dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_wfid(dispatch_wfid), .dispatch_pc(dispatch_pc),
    .fetch_stop_fetch(fetch_stop_fetch), .buff_ready(buff_ready),
    .buff2fetchwave_ack(buff2fetchwave_ack), .buff_ack_wfid(buff_ack_wfid),
    .salu_branch_en(salu_branch_en), .salu_branch_wfid(salu_branch_wfid),
    .salu_branch_taken(salu_branch_taken), .salu_branch_target(salu_branch_target),
    .issue_wf_done_en(issue_wf_done_en), .issue_wf_done_wf_id(issue_wf_done_wf_id),
    .fetch_reserve_valid(fetch_reserve_valid), .fetch_reserve_slotid(fetch_reserve_slotid),
    .fetch_buff_valid(fetch_buff_valid), .fetch_buff_wfid(fetch_buff_wfid),
    .fetch_buff_addr(fetch_buff_addr), .buff_squash(buff_squash),
    .active_count(active_count), .sched_err(sched_err)
  );
  int total = 0, bad = 0;
  int mst [40];
  logic [31:0] mpc [40];
  bit msq [40];
  bit mdr [40];
  int mrr;
  logic e_valid, e_err, e_sq, obs_sq;
  logic [5:0] e_wfid, e_cnt;
  logic [31:0] e_addr;
  int outq [$];
  int got [$];
  bit use_q = 0, pa = 0;
  logic [5:0] paw = '0;
  int exp_rr [6] = '{3, 17, 39, 3, 17, 39};
  int exp_st [4] = '{3, 39, 3, 39};
  int exp_cl [3] = '{3, 17, 39};
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  // model states: 0 idle, 1 ready, 2 waiting for its fetch to return
  task automatic model_step();
    int ns [40];
    logic [31:0] npc [40];
    bit nsq [40];
    bit ndr [40];
    int g, a, d, b, w, cnt;
    bit dn, bv, ak;
    e_sq = 0;
    if (rst) begin
      for (int i = 0; i < 40; i++) begin
        mst[i] = 0; mpc[i] = 0; msq[i] = 0; mdr[i] = 0;
      end
      mrr = 39; e_valid = 0; e_wfid = 0; e_addr = 0; e_cnt = 0; e_err = 0;
      return;
    end
    ns = mst; npc = mpc; nsq = msq; ndr = mdr;
    a = int'(buff_ack_wfid); d = int'(issue_wf_done_wf_id);
    b = int'(salu_branch_wfid); w = int'(dispatch_wfid);
    ak = buff2fetchwave_ack; dn = issue_wf_done_en;
    bv = salu_branch_en && salu_branch_taken && mst[b] != 0 && !(dn && d == b);
    if (ak) begin
      e_sq = msq[a] || (mst[a] != 2 && mdr[a]) || (mst[a] == 2 && ((dn && d == a) || (bv && b == a)));
      if (!(mst[a] == 2 || mdr[a])) e_err = 1;
    end
    g = -1;
    if (buff_ready)
      for (int k = 1; k <= 40; k++) begin
        int s;
        s = (mrr + k) % 40;
        if (g < 0 && mst[s] == 1 && !fetch_stop_fetch[s] && !(dn && d == s) &&
            !(salu_branch_en && salu_branch_taken && b == s)) g = s;
      end
    if (ak) begin
      ndr[a] = 0;
      if (mst[a] == 2 && !(dn && d == a) && !(bv && b == a)) begin ns[a] = 1; nsq[a] = 0; end
    end
    if (dn) begin
      ns[d] = 0; nsq[d] = 0;
      if (mst[d] == 2 && !(ak && a == d)) ndr[d] = 1;
    end
    if (bv) begin
      npc[b] = salu_branch_target;
      if (mst[b] == 2) begin
        if (ak && a == b) begin ns[b] = 1; nsq[b] = 0; end
        else nsq[b] = 1;
      end
    end
    e_valid = g >= 0;
    e_wfid = g >= 0 ? 6'(g) : 6'd0;
    e_addr = g >= 0 ? mpc[g] : 32'd0;
    if (g >= 0) begin
      ns[g] = 2; npc[g] = mpc[g] + 32'd4; mrr = g;
      if (use_q) outq.push_back(g);
    end
    if (dispatch_valid) begin
      if (ns[w] == 0) begin ns[w] = 1; npc[w] = dispatch_pc; nsq[w] = 0; end
      else e_err = 1;
    end
    mst = ns; mpc = npc; msq = nsq; mdr = ndr;
    cnt = 0;
    for (int i = 0; i < 40; i++) cnt += (mst[i] != 0) ? 1 : 0;
    e_cnt = 6'(cnt);
  endtask
  task automatic tick();
    @(negedge clk);
    model_step();
    chk("buff_squash", 32'(buff_squash), 32'(e_sq));
    obs_sq = buff_squash;
    @(posedge clk);
    #1;
    chk("buff_valid", 32'(fetch_buff_valid), 32'(e_valid));
    chk("reserve_valid", 32'(fetch_reserve_valid), 32'(e_valid));
    chk("buff_wfid", 32'(fetch_buff_wfid), 32'(e_wfid));
    chk("reserve_slot", 32'(fetch_reserve_slotid), 32'(e_wfid));
    chk("buff_addr", fetch_buff_addr, e_addr);
    chk("active_count", 32'(active_count), 32'(e_cnt));
    chk("sched_err", 32'(sched_err), 32'(e_err));
    dispatch_valid = 0; buff2fetchwave_ack = 0; salu_branch_en = 0; issue_wf_done_en = 0;
  endtask
  task automatic reset_dut();
    rst = 1; tick(); tick(); rst = 0; pa = 0;
  endtask
  task automatic disp(int w, logic [31:0] pc);
    dispatch_valid = 1; dispatch_wfid = 6'(w); dispatch_pc = pc;
  endtask
  task automatic ack(int w);
    buff2fetchwave_ack = 1; buff_ack_wfid = 6'(w);
  endtask
  task automatic branch(int w, logic [31:0] t);
    salu_branch_en = 1; salu_branch_taken = 1; salu_branch_wfid = 6'(w); salu_branch_target = t;
  endtask
  task automatic collect(int n);
    got.delete();
    for (int t = 0; t < 40 && got.size() < n; t++) begin
      if (pa) ack(int'(paw));
      pa = 0;
      tick();
      if (fetch_buff_valid) begin got.push_back(int'(fetch_buff_wfid)); pa = 1; paw = fetch_buff_wfid; end
    end
    chk("collect_count", 32'(got.size()), 32'(n));
  endtask
  initial begin
    reset_dut();
    chk("rst_valid", 32'(fetch_buff_valid), 32'd0);
    chk("rst_count", 32'(active_count), 32'd0);
    chk("rst_err", 32'(sched_err), 32'd0);
    buff_ready = 1; disp(17, 32'hcafe_f00d); tick();
    chk("launch_n1_valid", 32'(fetch_buff_valid), 32'd0);
    tick();
    chk("launch_valid", 32'(fetch_buff_valid), 32'd1);
    chk("launch_wfid", 32'(fetch_buff_wfid), 32'd17);
    chk("launch_addr", fetch_buff_addr, 32'hcafe_f00d);
    ack(17); tick(); tick();
    chk("launch_addr2", fetch_buff_addr, 32'hcafe_f011);
    reset_dut();
    buff_ready = 0; disp(3, 0); tick(); disp(17, 0); tick(); disp(39, 0); tick();
    buff_ready = 1;
    collect(6);
    for (int i = 0; i < 6; i++) if (i < got.size()) chk("rr_order", 32'(got[i]), 32'(exp_rr[i]));
    fetch_stop_fetch[17] = 1;
    collect(4);
    for (int i = 0; i < 4; i++) if (i < got.size()) chk("rr_stop", 32'(got[i]), 32'(exp_st[i]));
    fetch_stop_fetch = '0;
    collect(3);
    for (int i = 0; i < 3; i++) if (i < got.size()) chk("rr_unstop", 32'(got[i]), 32'(exp_cl[i]));
    reset_dut();
    buff_ready = 1; disp(5, 32'h1000); tick(); tick();
    branch(5, 32'h100); tick();
    ack(5); tick();
    chk("squash_ack", 32'(obs_sq), 32'd1);
    tick();
    chk("squash_refetch", fetch_buff_addr, 32'h100);
    reset_dut();
    buff_ready = 1; disp(9, 32'h40); tick();
    chk("done_cnt1", 32'(active_count), 32'd1);
    tick();
    issue_wf_done_en = 1; issue_wf_done_wf_id = 6'd9; tick();
    chk("done_cnt0", 32'(active_count), 32'd0);
    ack(9); tick();
    chk("drain_squash", 32'(obs_sq), 32'd1);
    chk("drain_err", 32'(sched_err), 32'd0);
    for (int i = 0; i < 5; i++) begin tick(); chk("drain_noreq", 32'(fetch_buff_valid), 32'd0); end
    reset_dut();
    buff_ready = 0; disp(4, 0); tick(); disp(4, 32'h8); tick();
    chk("err_disp", 32'(sched_err), 32'd1);
    tick(); tick();
    chk("err_sticky", 32'(sched_err), 32'd1);
    reset_dut();
    chk("err_cleared", 32'(sched_err), 32'd0);
    ack(20); tick();
    chk("err_ack_sq", 32'(obs_sq), 32'd0);
    chk("err_ack", 32'(sched_err), 32'd1);
    reset_dut();
    buff_ready = 1; disp(20, 0); tick(); tick();
    ack(20); buff_ready = 0; disp(10, 0); tick();
    disp(30, 0); tick(); disp(35, 0); tick();
    for (int i = 0; i < 10; i++) begin tick(); chk("bp_noreq", 32'(fetch_buff_valid), 32'd0); end
    buff_ready = 1; tick();
    chk("bp_grant", 32'(fetch_buff_wfid), 32'd30);
    reset_dut();
    buff_ready = 0; disp(7, 0); tick();
    issue_wf_done_en = 1; issue_wf_done_wf_id = 6'd7; disp(7, 32'h2000); tick();
    chk("done_disp_cnt", 32'(active_count), 32'd1);
    chk("done_disp_err", 32'(sched_err), 32'd0);
    buff_ready = 1; tick();
    chk("done_disp_addr", fetch_buff_addr, 32'h2000);
    buff_ready = 0; ack(7); tick();
    buff_ready = 1; branch(7, 32'h4000); tick();
    chk("br_grant_supp", 32'(fetch_buff_valid), 32'd0);
    tick();
    chk("br_grant_addr", fetch_buff_addr, 32'h4000);
    branch(7, 32'h5000); ack(7); tick();
    chk("br_ack_sq", 32'(obs_sq), 32'd1);
    tick();
    chk("br_ack_addr", fetch_buff_addr, 32'h5000);
    reset_dut();
    outq.delete(); use_q = 1;
    for (int c = 0; c < 3000; c++) begin
      int w;
      buff_ready = $urandom_range(0, 4) != 0;
      fetch_stop_fetch = ($urandom_range(0, 3) == 0) ? 40'({$urandom(), $urandom()}) : 40'd0;
      if ($urandom_range(0, 2) == 0) begin
        w = int'($urandom_range(0, 39));
        if (mst[w] == 0 && !mdr[w]) disp(w, $urandom() & 32'hffff_fffc);
      end
      if (outq.size() > 0 && $urandom_range(0, 1) == 1) ack(outq.pop_front());
      if ($urandom_range(0, 7) == 0) begin
        branch(int'($urandom_range(0, 39)), $urandom());
        salu_branch_taken = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 15) == 0) begin
        issue_wf_done_en = 1; issue_wf_done_wf_id = 6'($urandom_range(0, 39));
      end
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wf_fetch_scheduler.md
Name: wf_fetch_scheduler

Overview:
- Sits between the dispatcher, the wavepool and the instruction buffer.
- Tracks a PC and fetch state for each of up to 40 wavefront slots, and picks one eligible wavefront per cycle by round-robin.
- For the chosen wavefront it issues a fetch request to the instruction buffer and reserves a wavepool entry for it.
- Handles branch redirects, including squashing in-flight fetches, and wavefront retirement.

Parameters:
- NUM_WF, 40, number of wavefront slots
- WFID_W, 6, wavefront id width
- PC_W, 32, PC width
- PC_INC, 4, bytes the PC advances per issued fetch

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- dispatch_valid  in  1  new wavefront launch
- dispatch_wfid  in  6  slot for the new wavefront
- dispatch_pc  in  32  start PC
- fetch_stop_fetch  in  40  per-slot wavepool-full indication; blocks fetch for that slot
- buff_ready  in  1  instruction buffer can accept a request this cycle
- buff2fetchwave_ack  in  1  instruction buffer returns an instruction
- buff_ack_wfid  in  6  wfid of the returned instruction
- salu_branch_en  in  1  branch resolved
- salu_branch_wfid  in  6  wfid of the resolved branch
- salu_branch_taken  in  1  branch taken
- salu_branch_target  in  32  branch target PC
- issue_wf_done_en  in  1  wavefront retired
- issue_wf_done_wf_id  in  6  wfid of the retired wavefront
- fetch_reserve_valid  out  1  reserve a wavepool entry
- fetch_reserve_slotid  out  6  slot for the reservation
- fetch_buff_valid  out  1  fetch request to the instruction buffer
- fetch_buff_wfid  out  6  wfid of the request
- fetch_buff_addr  out  32  fetch PC
- buff_squash  out  1  combinational; current ack is stale and must be dropped
- active_count  out  6  number of slots not IDLE
- sched_err  out  1  sticky protocol-error flag

Behaviour:
- Per-slot state, 2-bit: IDLE, READY, PENDING. Each slot also holds pc[31:0] and a squash bit.
- Reset: all slots IDLE, pc=0, squash=0, rr_ptr=NUM_WF-1. Every output is 0.
- Dispatch:
  - IDLE -> READY, pc <= dispatch_pc, squash <= 0.
  - Dispatch to a non-IDLE slot is ignored and sets sched_err.
- Eligibility: slot i is eligible when state==READY and !fetch_stop_fetch[i].
- Arbitration:
  - When buff_ready=1, grant the first eligible slot scanning rr_ptr+1 upward, wrapping NUM_WF-1 -> 0.
  - On grant: rr_ptr <= granted slot, state <= PENDING, pc <= pc+PC_INC (mod 2^32).
  - At most one grant per cycle.
  - With buff_ready=0 or no eligible slot, no grant occurs and rr_ptr holds.
- Request outputs are registered. In the cycle after the grant:
  - fetch_buff_valid=fetch_reserve_valid=1 for exactly one cycle.
  - fetch_buff_wfid=fetch_reserve_slotid=the granted slot.
  - fetch_buff_addr=the pre-increment pc.
- Latency: dispatch at cycle N -> READY at N+1 -> earliest request outputs at N+2.
- Ack handling:
  - An ack for a PENDING slot sets state to READY.
  - buff_squash = ack & squash[buff_ack_wfid]; when it is 1, the squash bit clears.
  - An ack for a slot that is not PENDING sets sched_err and makes no state change.
- Branch with taken=1:
  - pc <= salu_branch_target.
  - If the slot is PENDING, set squash=1 and stay PENDING; the returning fetch is dropped and the slot then refetches from the target.
- Branch with taken=0: no change.
- Branch to an IDLE slot: ignored.
- Done: slot -> IDLE, squash cleared.
  - A later ack for that slot is still accepted: buff_squash=1, no sched_err.
  - Implementation: keep a per-slot drain bit set on done-while-PENDING and cleared on ack.
- Same-cycle events, priority per slot: done > branch > ack > grant.
  - Ack and taken branch in the same cycle for one PENDING slot: the ack is treated as stale (buff_squash=1), and the slot becomes READY with pc=target.
  - A slot granted in the same cycle as a taken branch to it: the grant is suppressed and pc=target.
  - Dispatch and done to the same slot in the same cycle: done applies first, then dispatch, so the slot ends READY.
- active_count is the registered population count of non-IDLE slots.
- sched_err clears only on rst.
- Reset asserted mid-operation: all state returns to reset values on the next edge. Outstanding acks arriving after reset are acks to an IDLE, non-draining slot: they set sched_err and drive buff_squash=0.

Decomposition:
- Shared package holds:
  - the state encodings WF_IDLE=2'd0, WF_READY=2'd1, WF_PENDING=2'd2
  - NUM_WF, WFID_W and PC_INC constants
- One sub-module, rr_arbiter_40: eligible[39:0], rr_ptr, en in -> grant_valid, grant_id[5:0], purely combinational.

Test Plan:
- Single launch: dispatch wfid 17, pc 32'hcafe_f00d, buff_ready=1 -> at N+2, fetch_buff_valid=1, wfid=17, addr=cafe_f00d. After the ack, the next request has addr=cafe_f011.
- Round-robin: dispatch wfids 3, 17, 39 and ack every request immediately -> grant order 3, 17, 39, 3, 17, 39. Raising fetch_stop_fetch[17] removes 17 from the rotation until it is cleared.
- Branch squash: slot 5 PENDING, branch taken to 32'h0000_0100 -> the next ack for 5 gives buff_squash=1, and the next request is addr 32'h0000_0100.
- Done while pending: slot 9 PENDING, done for 9 -> active_count decrements; the later ack gives buff_squash=1, sched_err=0, and no further requests come from 9.
- Errors: dispatch to a READY slot, and an ack for an IDLE non-draining slot -> sched_err=1 and stays set until rst.
- Backpressure: buff_ready=0 for 10 cycles with 4 slots READY -> no requests; the first cycle after buff_ready=1 grants the slot after rr_ptr.
